// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU with HI/LO result and pipeline stall request.
// Optional `DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_req
);

    localparam int unsigned LAST = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
    logic               neg_quo_q, neg_rem_q;

    logic [WIDTH-1:0]   abs_a_c, abs_b_c;
    logic [WIDTH:0]     partial_c, diff_c;
    logic [WIDTH-1:0]   rem_step_c, quo_step_c;
    logic [2*WIDTH-1:0] fixed_c, early_res_c;
    logic               last_c, early_c, go_c;

    // Operand magnitudes; the most negative value maps onto itself, which is correct as unsigned.
    assign abs_a_c = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
    assign abs_b_c = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;
    assign go_c    = start && !annul;
    assign last_c  = (cnt == CNT_W'(LAST));

`ifdef DIV_EARLY_EXIT_EN
    assign early_c = (abs_a_c < abs_b_c);
`else
    assign early_c = 1'b0;
`endif
    assign early_res_c = {opdata1, WIDTH'(0)};

    // One restoring step: partial remainder never exceeds 2*divisor, so WIDTH+1 bits suffice.
    assign partial_c  = {rem_q, dvd_q[WIDTH-1]};
    assign diff_c     = partial_c - {1'b0, dvs_q};
    assign rem_step_c = diff_c[WIDTH] ? partial_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    assign quo_step_c = {dvd_q[WIDTH-2:0], ~diff_c[WIDTH]};

    // Sign fix-up applied to the final step as the result is captured.
    assign fixed_c = {neg_rem_q ? (~rem_step_c + WIDTH'(1)) : rem_step_c,
                      neg_quo_q ? (~quo_step_c + WIDTH'(1)) : quo_step_c};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        stall_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (go_c) begin
                    stall_req = 1'b1;
                    if (opdata2 == '0) state_n = DIVZERO;
                    else if (early_c)  state_n = DONE;
                    else               state_n = BUSY;
                end
            end
            DIVZERO: begin
                stall_req = 1'b1;
                state_n   = annul ? IDLE : DONE;
            end
            BUSY: begin
                stall_req = 1'b1;
                if (annul)       state_n = IDLE;
                else if (last_c) state_n = DONE;
            end
            DONE: begin
                if (!start || annul) state_n = IDLE;
            end
        endcase
    end

    // Datapath and registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            if (state == IDLE && go_c) begin
                cnt       <= '0;
                rem_q     <= '0;
                dvd_q     <= abs_a_c;
                dvs_q     <= abs_b_c;
                neg_quo_q <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                neg_rem_q <= signed_div && opdata1[WIDTH-1];
            end else if (state == BUSY) begin
                cnt   <= cnt + CNT_W'(1);
                rem_q <= rem_step_c;
                dvd_q <= quo_step_c;
            end

            ready <= (state_n == DONE);
            if (state_n != DONE)    result <= '0;
            else if (state == BUSY) result <= fixed_c;
            else if (state == IDLE) result <= early_res_c;
            else if (state == DIVZERO) result <= '0;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: table of divides plus annul and mid-operation reset sequences.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int checks = 0;
    int failures = 0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .result(result), .ready(ready), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SHORT_LAT = 1;
`else
    localparam int SHORT_LAT = 33;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide with start held until ready, then release start.
    task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input int lat);
        int n;
        int stalls;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1;
        n = 0;
        stalls = stall_req ? 1 : 0;
        while (n < 100) begin
            tick();
            n++;
            opdata1 = ~a;
            opdata2 = b ^ 32'h0000_0005;
            if (ready) break;
            if (stall_req) stalls++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " stall cycles"}, 64'(stalls), 64'(lat));
        chk({name, " result"}, result, {r, q});
        chk({name, " stall in done"}, 64'(stall_req), 64'd0);
        tick();
        chk({name, " ready held"}, 64'(ready), 64'd1);
        chk({name, " result held"}, result, {r, q});
        start = 1'b0;
        tick();
        chk({name, " ready after drop"}, 64'(ready), 64'd0);
        chk({name, " result after drop"}, result, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 33});
        vecs.push_back('{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 33});
        vecs.push_back('{"div_7_m2",     1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, 33});
        vecs.push_back('{"div_5_0",      1'b1, 32'd5,          32'd0,          32'd0,         32'd0,         2});
        vecs.push_back('{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 33});
        vecs.push_back('{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'd0,         33});
        vecs.push_back('{"divu_max_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         32'd0,         33});
        vecs.push_back('{"div_m1_m1",    1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         32'd0,         33});
        vecs.push_back('{"divu_3_10",    1'b0, 32'd3,          32'd10,         32'd0,         32'd3,         SHORT_LAT});
        vecs.push_back('{"div_m3_10",    1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,         32'hFFFF_FFFD, SHORT_LAT});

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        tick();
        tick();
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset stall", 64'(stall_req), 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_div(vecs[i].name, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);

        // Annul in BUSY: back to IDLE, no ready, then a clean retry.
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        begin
            int rdy_seen;
            rdy_seen = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (ready) rdy_seen++;
            end
            chk("annul stall busy", 64'(stall_req), 64'd1);
            annul = 1'b1; start = 1'b0;
            tick();
            annul = 1'b0;
            if (ready) rdy_seen++;
            chk("annul stall", 64'(stall_req), 64'd0);
            chk("annul result", result, 64'd0);
            for (int c = 0; c < 40; c++) begin
                tick();
                if (ready) rdy_seen++;
            end
            chk("annul ready never", 64'(rdy_seen), 64'd0);
        end
        run_div("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        // Reset in BUSY cycle 20.
        signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd7; start = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("pre-reset stall", 64'(stall_req), 64'd1);
        rst = 1'b1; start = 1'b0;
        tick();
        chk("midreset ready", 64'(ready), 64'd0);
        chk("midreset stall", 64'(stall_req), 64'd0);
        chk("midreset result", result, 64'd0);
        rst = 1'b0;
        tick();
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
